button_debounce_latch: RTL and testbench

- Front end for the four game buttons. It synchronizes and debounces each raw input and detects press events.
- It latches the first press into a one-word mailbox and clears that mailbox once the processor has read it.
- Sits directly upstream of the memory-mapped read mux: its button_out drives the load data returned for address 7, and the mux's address-7 decode drives poll.
- The button_out encoding matches the colour/on bit layout used by the LED and audio store paths, so software can forward a read word unchanged.

---
 rtl/button_debounce_latch_pkg.sv | 21 ++
 rtl/button_debounce_latch_if.sv | 34 +++
 rtl/button_debounce_latch_debounce_channel.sv | 55 +++++
 rtl/button_debounce_latch.sv | 129 ++++++++++++
 tb/tb_button_debounce_latch.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_debounce_latch_pkg.sv
// Shared definitions for the game-button front end.
//   - Colour codes used in button_out[2:1]. They match the LED and audio
//     store word layout, so software can forward a read word unchanged.
//   - Mailbox FSM state encoding.
//   - MMIO address decoded by the read mux to drive poll.
package button_debounce_latch_pkg;

    localparam logic [1:0] COLOR_RED    = 2'b00;
    localparam logic [1:0] COLOR_BLUE   = 2'b01;
    localparam logic [1:0] COLOR_GREEN  = 2'b10;
    localparam logic [1:0] COLOR_YELLOW = 2'b11;

    localparam logic [11:0] BUTTON_ADDR = 12'd7;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_FULL    = 2'b01,
        ST_READING = 2'b10
    } mailbox_state_t;

endpackage

// File: rtl/button_debounce_latch_if.sv
// Button/processor side bundle of the button front end.
//   red/blue/green/yellow_button : raw active-high buttons (async to clock)
//   poll                         : high while the processor reads address 7
//   button_out                   : [0] valid, [2:1] colour, [31:3] zero
// slave  : the front end itself (consumes buttons and poll, drives button_out)
// master : the environment (drives buttons and poll, reads button_out)
interface button_debounce_latch_if;

    logic        red_button;
    logic        blue_button;
    logic        green_button;
    logic        yellow_button;
    logic        poll;
    logic [31:0] button_out;

    modport master (
        output red_button,
        output blue_button,
        output green_button,
        output yellow_button,
        output poll,
        input  button_out
    );

    modport slave (
        input  red_button,
        input  blue_button,
        input  green_button,
        input  yellow_button,
        input  poll,
        output button_out
    );

endinterface

// File: rtl/button_debounce_latch_debounce_channel.sv
// One button channel: 2-flop synchronizer, stability counter, debounced
// level and a registered one-cycle press pulse.
//   clock  : system clock
//   reset  : asynchronous, active-high
//   raw    : raw button level, asynchronous to clock
//   rise   : one-cycle pulse when the debounced level goes 0 -> 1
// The debounced level changes only after the synchronized input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
module button_debounce_latch_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg == level_reg) begin
                // Any agreeing cycle restarts the stability window.
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
                cnt_reg   <= '0;
                level_reg <= sync2_reg;
                rise_reg  <= sync2_reg;   // only 0 -> 1 is a press
            end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/button_debounce_latch.sv
// Game-button front end feeding the address-7 slot of the MMIO read mux.
//   clock : system clock (50 MHz)
//   reset : asynchronous, active-high; clears all state
//   bus   : slave side of button_debounce_latch_if (buttons, poll, button_out)
// Each button is debounced independently; press pulses are priority encoded
// (red > blue > green > yellow) and the first press is held in a one-word
// mailbox until the processor has finished reading it. A press that matures
// while a read is in progress waits in a one-entry pending slot.
module button_debounce_latch
    import button_debounce_latch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                    clock,
    input  logic                    reset,
    button_debounce_latch_if.slave  bus
);

    // Index order matches the priority order: bit 0 = red (highest).
    logic [3:0] raw;
    logic [3:0] rise;

    assign raw = {bus.yellow_button, bus.green_button, bus.blue_button, bus.red_button};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            button_debounce_latch_debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_chan (
                .clock (clock),
                .reset (reset),
                .raw   (raw[gi]),
                .rise  (rise[gi])
            );
        end
    endgenerate

    // Priority encode; lower-priority presses in the same cycle are dropped.
    logic       event_valid;
    logic [1:0] event_colour;

    always_comb begin
        event_valid  = |rise;
        event_colour = COLOR_RED;
        if (rise[0])      event_colour = COLOR_RED;
        else if (rise[1]) event_colour = COLOR_BLUE;
        else if (rise[2]) event_colour = COLOR_GREEN;
        else if (rise[3]) event_colour = COLOR_YELLOW;
    end

    // Mailbox FSM
    mailbox_state_t state_reg, state_next;
    logic           mail_valid_reg, mail_valid_next;
    logic [1:0]     mail_colour_reg, mail_colour_next;
    logic           pend_valid_reg, pend_valid_next;
    logic [1:0]     pend_colour_reg, pend_colour_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_EMPTY;
            mail_valid_reg  <= 1'b0;
            mail_colour_reg <= COLOR_RED;
            pend_valid_reg  <= 1'b0;
            pend_colour_reg <= COLOR_RED;
        end else begin
            state_reg       <= state_next;
            mail_valid_reg  <= mail_valid_next;
            mail_colour_reg <= mail_colour_next;
            pend_valid_reg  <= pend_valid_next;
            pend_colour_reg <= pend_colour_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        mail_valid_next  = mail_valid_reg;
        mail_colour_next = mail_colour_reg;
        pend_valid_next  = pend_valid_reg;
        pend_colour_next = pend_colour_reg;

        unique case (state_reg)
            ST_EMPTY: begin
                if (bus.poll) begin
                    // The word being read must stay 0, so a coincident press
                    // goes to the pending slot instead of the mailbox.
                    state_next = ST_READING;
                    if (event_valid) begin
                        pend_valid_next  = 1'b1;
                        pend_colour_next = event_colour;
                    end
                end else if (event_valid) begin
                    mail_valid_next  = 1'b1;
                    mail_colour_next = event_colour;
                    state_next       = ST_FULL;
                end
            end
            ST_FULL: begin
                // First press wins; later presses are ignored here.
                if (bus.poll) state_next = ST_READING;
            end
            ST_READING: begin
                if (bus.poll) begin
                    // Output frozen for the whole read.
                    if (event_valid && !pend_valid_reg) begin
                        pend_valid_next  = 1'b1;
                        pend_colour_next = event_colour;
                    end
                end else if (pend_valid_reg) begin
                    mail_valid_next  = 1'b1;
                    mail_colour_next = pend_colour_reg;
                    pend_valid_next  = 1'b0;
                    state_next       = ST_FULL;
                end else begin
                    mail_valid_next  = 1'b0;
                    mail_colour_next = COLOR_RED;
                    state_next       = ST_EMPTY;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    assign bus.button_out = {29'd0, mail_colour_reg, mail_valid_reg};

endmodule

// File: tb/tb_button_debounce_latch.sv
// Directed bench for button_debounce_latch with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, so "after edge n" below means that sampling point.
module tb_button_debounce_latch;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    button_debounce_latch_if bus();

    button_debounce_latch #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Short poll pulse to empty the mailbox (used between scenarios).
    task automatic drain();
        bus.poll = 1'b1;
        tick(1);
        bus.poll = 1'b0;
        tick(1);
        checks++;
        if (bus.button_out !== 32'h0) begin
            errors++;
            $display("FAIL drain: button_out=%h expected=%h", bus.button_out, 32'h0);
        end
    endtask

    task automatic test_reset();
        bus.red_button    = 1'b0;
        bus.blue_button   = 1'b0;
        bus.green_button  = 1'b0;
        bus.yellow_button = 1'b0;
        bus.poll          = 1'b0;
        reset             = 1'b1;
        #1;
        checks++;
        if (bus.button_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_assert: button_out=%h expected=%h", bus.button_out, 32'h0);
        end
        tick(3);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checks++;
            if (bus.button_out !== 32'h0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: button_out=%h expected=%h", i, bus.button_out, 32'h0);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_bounce();
        bus.green_button = 1'b1;
        tick(3);
        bus.green_button = 1'b0;
        tick(1);
        bus.green_button = 1'b1;
        tick(2);
        bus.green_button = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            checks++;
            if (bus.button_out !== 32'h0) begin
                errors++;
                $display("FAIL bounce cycle %0d: button_out=%h expected=%h", i, bus.button_out, 32'h0);
            end
        end
        $display("test_bounce done");
    endtask

    task automatic test_same_cycle();
        bus.red_button  = 1'b1;
        bus.blue_button = 1'b1;
        tick(6);
        checks++;
        if (bus.button_out !== 32'h0) begin
            errors++;
            $display("FAIL same_cycle_early: button_out=%h expected=%h", bus.button_out, 32'h0);
        end
        tick(1);
        checks++;
        if (bus.button_out !== 32'h1) begin
            errors++;
            $display("FAIL same_cycle_red: button_out=%h expected=%h", bus.button_out, 32'h1);
        end
        bus.poll = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if (bus.button_out !== 32'h1) begin
                errors++;
                $display("FAIL same_cycle_read %0d: button_out=%h expected=%h", i, bus.button_out, 32'h1);
            end
        end
        bus.poll = 1'b0;
        tick(1);
        checks++;
        if (bus.button_out !== 32'h0) begin
            errors++;
            $display("FAIL same_cycle_cleared: button_out=%h expected=%h", bus.button_out, 32'h0);
        end
        bus.red_button  = 1'b0;
        bus.blue_button = 1'b0;
        tick(12);
        checks++;
        if (bus.button_out !== 32'h0) begin
            errors++;
            $display("FAIL same_cycle_blue_dropped: button_out=%h expected=%h", bus.button_out, 32'h0);
        end
        $display("test_same_cycle done");
    endtask

    task automatic test_mid_read();
        bus.blue_button = 1'b1;
        tick(7);
        checks++;
        if (bus.button_out !== 32'h3) begin
            errors++;
            $display("FAIL mid_read_blue: button_out=%h expected=%h", bus.button_out, 32'h3);
        end
        bus.blue_button = 1'b0;
        tick(8);
        // green raised after edge k, poll high for edges k+5..k+9
        bus.green_button = 1'b1;
        tick(4);
        bus.poll = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++;
            if (bus.button_out !== 32'h3) begin
                errors++;
                $display("FAIL mid_read_frozen %0d: button_out=%h expected=%h", i, bus.button_out, 32'h3);
            end
        end
        bus.poll = 1'b0;
        tick(1);
        checks++;
        if (bus.button_out !== 32'h5) begin
            errors++;
            $display("FAIL mid_read_pending: button_out=%h expected=%h", bus.button_out, 32'h5);
        end
        bus.green_button = 1'b0;
        tick(8);
        drain();
        $display("test_mid_read done");
    endtask

    task automatic test_poll_event_collide();
        // red press reaches the FSM at edge k+7, exactly when poll first rises
        bus.red_button = 1'b1;
        tick(6);
        bus.poll = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if (bus.button_out !== 32'h0) begin
                errors++;
                $display("FAIL collide_read %0d: button_out=%h expected=%h", i, bus.button_out, 32'h0);
            end
        end
        bus.poll = 1'b0;
        tick(1);
        checks++;
        if (bus.button_out !== 32'h1) begin
            errors++;
            $display("FAIL collide_pending: button_out=%h expected=%h", bus.button_out, 32'h1);
        end
        bus.red_button = 1'b0;
        tick(8);
        drain();
        $display("test_poll_event_collide done");
    endtask

    task automatic test_hold();
        bus.yellow_button = 1'b1;
        tick(6);
        checks++;
        if (bus.button_out !== 32'h0) begin
            errors++;
            $display("FAIL hold_early: button_out=%h expected=%h", bus.button_out, 32'h0);
        end
        tick(1);
        checks++;
        if (bus.button_out !== 32'h7) begin
            errors++;
            $display("FAIL hold_yellow: button_out=%h expected=%h", bus.button_out, 32'h7);
        end
        for (int i = 0; i < 50; i++) begin
            tick(1);
            checks++;
            if (bus.button_out !== 32'h7) begin
                errors++;
                $display("FAIL hold_steady %0d: button_out=%h expected=%h", i, bus.button_out, 32'h7);
            end
        end
        $display("test_hold done");
    endtask

    task automatic test_reset_mid();
        // mailbox holds 32'h7 from test_hold
        bus.yellow_button = 1'b0;
        bus.red_button    = 1'b1;
        tick(3);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.button_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_clear: button_out=%h expected=%h", bus.button_out, 32'h0);
        end
        tick(1);
        reset = 1'b0;
        tick(6);
        checks++;
        if (bus.button_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_early: button_out=%h expected=%h", bus.button_out, 32'h0);
        end
        tick(1);
        checks++;
        if (bus.button_out !== 32'h1) begin
            errors++;
            $display("FAIL reset_mid_red: button_out=%h expected=%h", bus.button_out, 32'h1);
        end
        bus.red_button = 1'b0;
        $display("test_reset_mid done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_bounce();
        test_same_cycle();
        test_mid_read();
        test_poll_event_collide();
        test_hold();
        test_reset_mid();
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
